// File: rtl/serial_tx_sched.sv
// Round-robin scheduler sharing one ser_clk/ser_data link between NUM_REQ requesters.
// Each granted word is shifted out with a divided bit clock, followed by an idle gap.
//
// state | meaning
// IDLE  | link idle-high; arbitrate among pending requests
// SHIFT | serializing the latched word, 2*HALF_DIV clk cycles per bit
// GAP   | link idle-high for IDLE_BITS bit-periods before re-arbitration
module serial_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int HALF_DIV   = 5,
    parameter int TRANS_EDGE = 1,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_BITS  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [$clog2(NUM_REQ)-1:0]     cur_id,
    output logic                           busy,
    output logic                           done,
    output logic                           ser_clk,
    output logic                           ser_data
);
    localparam int IW      = $clog2(NUM_REQ);
    localparam int HW      = $clog2(HALF_DIV + 1);
    localparam int BW      = $clog2(DATA_WIDTH + 1);
    localparam int GAP_LEN = IDLE_BITS * 2 * HALF_DIV;
    localparam int GW      = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [IW:0]    NR        = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0]  LAST_REQ  = IW'(NUM_REQ - 1);
    localparam logic [HW-1:0]  HALF_LOAD = HW'(HALF_DIV - 1);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0]  GAP_LOAD  = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    // ser_clk level during the first half of each bit; flips on the data edge
    localparam logic           FIRST_CLK = (TRANS_EDGE == 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           ptr, ptr_n, cur_id_n, win;
    logic [IW:0]             scan_idx;
    logic                    found;
    logic [DATA_WIDTH-1:0]   shreg, shreg_n;
    logic [HW-1:0]           hcnt, hcnt_n;
    logic                    half, half_n;
    logic [BW-1:0]           bcnt, bcnt_n;
    logic [GW-1:0]           gcnt, gcnt_n;
    logic [NUM_REQ-1:0]      grant_n;
    logic                    busy_n, done_n, ser_clk_n, ser_data_n;

    // first pending requester at or after ptr, scanning upward with wrap
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + (IW+1)'(i);
            if (scan_idx >= NR)
                scan_idx = scan_idx - NR;
            if (!found && req[scan_idx[IW-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cur_id_n   = cur_id;
        shreg_n    = shreg;
        hcnt_n     = hcnt;
        half_n     = half;
        bcnt_n     = bcnt;
        gcnt_n     = gcnt;
        grant_n    = '0;
        ser_clk_n  = ser_clk;
        ser_data_n = ser_data;
        case (state)
            IDLE: begin
                ser_clk_n  = 1'b1;
                ser_data_n = 1'b1;
                if (found) begin
                    state_n       = SHIFT;
                    grant_n[win]  = 1'b1;
                    shreg_n       = data[win*DATA_WIDTH +: DATA_WIDTH];
                    cur_id_n      = win;
                    ptr_n         = (win == LAST_REQ) ? '0 : win + 1'b1;
                    hcnt_n        = HALF_LOAD;
                    half_n        = 1'b0;
                    bcnt_n        = '0;
                    ser_clk_n     = FIRST_CLK;
                end
            end
            SHIFT: begin
                if (hcnt != '0) begin
                    hcnt_n = hcnt - 1'b1;
                end else if (!half) begin
                    half_n     = 1'b1;
                    hcnt_n     = HALF_LOAD;
                    ser_clk_n  = ~FIRST_CLK;
                    ser_data_n = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
                end else if (bcnt == LAST_BIT) begin
                    ser_clk_n  = 1'b1;
                    ser_data_n = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_n = GAP;
                        gcnt_n  = GAP_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bcnt_n    = bcnt + 1'b1;
                    half_n    = 1'b0;
                    hcnt_n    = HALF_LOAD;
                    ser_clk_n = FIRST_CLK;
                    shreg_n   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                end
            end
            GAP: begin
                ser_clk_n  = 1'b1;
                ser_data_n = 1'b1;
                if (gcnt == '0)
                    state_n = IDLE;
                else
                    gcnt_n = gcnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
        // done marks the final cycle of the frame, so it is decoded from the next-cycle view
        done_n = ((GAP_LEN == 0) && (state_n == SHIFT) && half_n && (hcnt_n == '0) && (bcnt_n == LAST_BIT))
              || ((state_n == GAP) && (gcnt_n == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            shreg    <= '0;
            hcnt     <= '0;
            half     <= 1'b0;
            bcnt     <= '0;
            gcnt     <= '0;
            grant    <= '0;
            cur_id   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ser_clk  <= 1'b1;
            ser_data <= 1'b1;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            shreg    <= shreg_n;
            hcnt     <= hcnt_n;
            half     <= half_n;
            bcnt     <= bcnt_n;
            gcnt     <= gcnt_n;
            grant    <= grant_n;
            cur_id   <= cur_id_n;
            busy     <= busy_n;
            done     <= done_n;
            ser_clk  <= ser_clk_n;
            ser_data <= ser_data_n;
        end
    end
endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: three configurations checked every cycle against a
// frame-offset model, plus directed expectations for bit order, frame length and arbitration.
module tb_serial_tx_sched;
    localparam int HD [3] = '{5, 2, 1};
    localparam int TE [3] = '{1, 0, 1};
    localparam int MF [3] = '{1, 0, 1};
    localparam int IB [3] = '{1, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0]  req [3];
    logic [31:0] data [3];
    logic [3:0]  grant [3];
    logic [1:0]  cur_id [3];
    logic        busy [3], done [3], ser_clk [3], ser_data [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .HALF_DIV(5), .TRANS_EDGE(1), .MSB_FIRST(1), .IDLE_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .data(data[0]), .grant(grant[0]), .cur_id(cur_id[0]),
        .busy(busy[0]), .done(done[0]), .ser_clk(ser_clk[0]), .ser_data(ser_data[0]));
    serial_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .HALF_DIV(2), .TRANS_EDGE(0), .MSB_FIRST(0), .IDLE_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .data(data[1]), .grant(grant[1]), .cur_id(cur_id[1]),
        .busy(busy[1]), .done(done[1]), .ser_clk(ser_clk[1]), .ser_data(ser_data[1]));
    serial_tx_sched #(.NUM_REQ(4), .DATA_WIDTH(8), .HALF_DIV(1), .TRANS_EDGE(1), .MSB_FIRST(1), .IDLE_BITS(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .data(data[2]), .grant(grant[2]), .cur_id(cur_id[2]),
        .busy(busy[2]), .done(done[2]), .ser_clk(ser_clk[2]), .ser_data(ser_data[2]));

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic int flen(input int k);
        return (8 + IB[k]) * 2 * HD[k];
    endfunction

    // {ser_clk, ser_data} at offset o from the grant cycle
    function automatic logic [1:0] link(input int k, input int o, input logic [7:0] w);
        int h, i, ph;
        logic b, pb;
        h = HD[k];
        if (o >= 16 * h) return 2'b11;
        i  = o / (2 * h);
        ph = o % (2 * h);
        b  = (MF[k] != 0) ? w[7 - i] : w[i];
        if (i == 0) pb = 1'b1;
        else        pb = (MF[k] != 0) ? w[8 - i] : w[i - 1];
        if (ph < h) return {(TE[k] == 0), pb};
        return {(TE[k] != 0), b};
    endfunction

    bit         m_act [3];
    int         m_g [3], m_win [3], m_ptr [3], m_id [3];
    logic [7:0] m_word [3];
    logic       prev_clk [3];
    logic [7:0] cap [3];
    int         capn [3];

    always @(negedge clk) begin
        int o, w, idx;
        bit inf;
        logic [9:0] expv, actv;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_act[k] = 1'b0; m_ptr[k] = 0; m_id[k] = 0; prev_clk[k] = 1'b1;
            end else begin
                o    = cyc - m_g[k];
                inf  = m_act[k] && (o < flen(k));
                expv = {(inf && o == 0) ? 4'(1 << m_win[k]) : 4'b0, 2'(m_id[k]), inf,
                        (inf && o == flen(k) - 1), inf ? link(k, o, m_word[k]) : 2'b11};
                actv = {grant[k], cur_id[k], busy[k], done[k], ser_clk[k], ser_data[k]};
                chk($sformatf("u%0d cyc%0d {grant,id,busy,done,sclk,sdat}", k, cyc), int'(actv), int'(expv));
                if (grant[k] != 4'b0) begin
                    cap[k] = 8'h00; capn[k] = 0;
                end else if (busy[k] && ser_clk[k] != prev_clk[k] && ser_clk[k] == (TE[k] != 0)) begin
                    cap[k] = {cap[k][6:0], ser_data[k]}; capn[k]++;
                end
                prev_clk[k] = ser_clk[k];
                if ((!m_act[k] || o >= flen(k)) && req[k] != 4'b0) begin
                    w = -1;
                    for (int j = 0; j < 4; j++) begin
                        idx = (m_ptr[k] + j) % 4;
                        if (w < 0 && req[k][idx]) w = idx;
                    end
                    m_act[k]  = 1'b1;
                    m_g[k]    = cyc + 1;
                    m_win[k]  = w;
                    m_word[k] = data[k][w*8 +: 8];
                    m_ptr[k]  = (w + 1) % 4;
                    m_id[k]   = w;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int k, output int gc, output int gid, output int gval);
        gc = -1; gid = -1; gval = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (grant[k] != 4'b0) begin
                gc = cyc; gval = int'(grant[k]);
                for (int j = 0; j < 4; j++) if (grant[k][j]) gid = j;
                break;
            end
        end
        chk($sformatf("u%0d grant seen", k), int'(gc >= 0), 1);
    endtask

    task automatic wait_done(input int k, output int dc);
        dc = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done[k]) begin
                dc = cyc;
                break;
            end
        end
        chk($sformatf("u%0d done seen", k), int'(dc >= 0), 1);
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s u%0d outputs", tag, k),
                int'({grant[k], cur_id[k], busy[k], done[k], ser_clk[k], ser_data[k]}), 'b0000_00_0_0_1_1);
    endtask

    task automatic single(input int k, input logic [7:0] word, input logic [3:0] pat, input int exp_id,
                          input int exp_bits, input int exp_len);
        int gc, gid, gval, dc;
        step();
        data[k][7:0] = word;
        req[k] = pat;
        wait_grant(k, gc, gid, gval);
        chk($sformatf("u%0d grant onehot", k), gval, 1 << exp_id);
        step();
        req[k] = 4'b0;
        data[k] = 32'h0;
        wait_done(k, dc);
        chk($sformatf("u%0d frame length", k), dc - gc + 1, exp_len);
        step();
        chk($sformatf("u%0d bit count", k), capn[k], 8);
        chk($sformatf("u%0d bits", k), int'(cap[k]), exp_bits);
    endtask

    initial begin
        int gc, gid, gval, prev;
        int rr [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 3; k++) begin
            req[k] = 4'b0; data[k] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("power-on");
        rst_n = 1'b1;

        single(0, 8'h85, 4'b0001, 0, 'h85, 90);
        single(1, 8'h85, 4'b0001, 0, 'hA1, 36);
        single(2, 8'hFF, 4'b0001, 0, 'hFF, 16);

        // round-robin with all requests held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        data[0] = 32'h3C5AE796;
        req[0] = 4'b1111;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(0, gc, gid, gval);
            chk($sformatf("rr grant %0d id", n), gid, rr[n]);
            if (n > 0) chk($sformatf("rr grant %0d spacing", n), gc - prev, 2);
            if (n == 4) begin
                step();
                req[0] = 4'b1000;
            end
            wait_done(0, prev);
        end
        wait_grant(0, gc, gid, gval);
        chk("wrap grant id", gid, 3);
        chk("wrap grant spacing", gc - prev, 2);
        step();
        req[0] = 4'b0110;
        repeat (10) step();
        req[0] = 4'b0100;
        wait_done(0, prev);
        wait_grant(0, gc, gid, gval);
        chk("withdraw grant id", gid, 2);
        chk("withdraw grant onehot", gval, 4'b0100);
        step();
        req[0] = 4'b1111;
        wait_done(0, prev);
        wait_grant(0, gc, gid, gval);
        chk("pointer after 2", gid, 3);
        step();
        req[0] = 4'b0;
        wait_done(0, prev);

        // reset during bit 3 of a frame
        step();
        req[0] = 4'b0100;
        wait_grant(0, gc, gid, gval);
        step();
        req[0] = 4'b0;
        repeat (31) @(posedge clk);
        #2;
        chk("busy before reset", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid-frame reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        single(0, 8'h85, 4'b1111, 0, 'h85, 90);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_tx_sched.md
# serial_tx_sched

Synthesizable serial transmit scheduler that shares one two-wire serial link (ser_clk / ser_data) between NUM_REQ requesters. Each requester presents a parallel word and a request. The block arbitrates round-robin, latches the winning word, and serializes it with a divided bit clock. It then inserts a programmable idle gap before the next frame. It is the RTL counterpart of the bench serial generator and drives the same link format: selectable update edge, MSB/LSB order, idle-high lines.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, bits per frame (>=1)
- HALF_DIV, 5, clk cycles per ser_clk half-period (>=1)
- TRANS_EDGE, 1, 1: data changes with ser_clk rising edge; 0: with falling edge
- MSB_FIRST, 1, 1: bit DATA_WIDTH-1 first; 0: bit 0 first
- IDLE_BITS, 1, idle bit-periods inserted after each frame (>=0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request, level, held until grant
- data  in  NUM_REQ*DATA_WIDTH  requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
- grant  out  NUM_REQ  one-hot, one-cycle pulse; word captured on that cycle
- cur_id  out  $clog2(NUM_REQ)  index of the requester currently transmitting
- busy  out  1  high from grant cycle through last gap cycle
- done  out  1  one-cycle pulse on final cycle of frame (including gap)
- ser_clk  out  1  serial clock
- ser_data  out  1  serial data

## Operation
- All outputs are registered.
- Reset values: grant=0, cur_id=0, busy=0, done=0, ser_clk=1, ser_data=1. The round-robin pointer is reset to 0.
- Reset asserted mid-frame aborts the frame immediately: outputs go to reset values and the frame is not resumed.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ser_clk=1, ser_data=1.
  - If any req is high, pick the first requester at or after pointer, scanning upward with wrap.
  - Pulse grant for that requester, latch its data, set cur_id, set pointer to winner+1 (mod NUM_REQ), and enter SHIFT with bit counter=0.
- SHIFT: each bit lasts 2*HALF_DIV clk cycles.
  - TRANS_EDGE=1:
    - First half: ser_clk=0, ser_data holds the previous value.
    - Second half, first cycle: ser_clk=1 and ser_data=current bit, both updated on the same edge.
  - TRANS_EDGE=0: same as TRANS_EDGE=1 with ser_clk polarity inverted (first half 1, second half 0).
  - Bit order: MSB_FIRST=1 sends the latched word from bit DATA_WIDTH-1 down to bit 0; otherwise from bit 0 up.
  - After the last bit's second half, go to GAP if IDLE_BITS>0, else to IDLE.
- GAP:
  - ser_clk=1, ser_data=1 for IDLE_BITS*2*HALF_DIV cycles, then go to IDLE.
- done pulses on the last cycle before returning to IDLE.
  - IDLE_BITS=0: the last cycle of the last bit.
- busy is high from the grant cycle through the done cycle inclusive.
- Arbitration happens only in IDLE. req changes during SHIFT/GAP are ignored until return to IDLE.
- A req dropped before grant is withdrawn; no grant is issued for it.
- data and req of the granted requester may change after the grant cycle without affecting the frame.
- Counters:
  - Half-period counter: $clog2(HALF_DIV+1) bits.
  - Bit counter: $clog2(DATA_WIDTH+1) bits.
  - Gap counter: $clog2(IDLE_BITS*2*HALF_DIV+1) bits, minimum 1.

## Timing
- Latency: req high at edge t while in IDLE -> grant high, busy high, ser_clk low (TRANS_EDGE=1) during cycle t+1.
- First data bit is driven at cycle t+1+HALF_DIV.
- Bit i occupies cycles t+1+2*i*HALF_DIV .. t+(2*i+2)*HALF_DIV.
- Frame length from grant to done inclusive: (DATA_WIDTH+IDLE_BITS)*2*HALF_DIV cycles.
- Back-to-back: the cycle after done is IDLE. The next grant is asserted at the earliest one cycle after that, so there are 2 cycles between done and the next grant.
- Simultaneous requests: exactly one grant per frame, in round-robin order. No requester is starved while its req is held.
- grant and done never assert in the same cycle.

## Test plan
- Single frame, defaults:
  - Stimulus: req[0]=1 with data[7:0]=8'h85.
  - Required: grant=4'b0001 one cycle; ser_data sampled at ser_clk rising edges = 1,0,0,0,0,1,0,1; done 80+10=90 cycles after grant inclusive; ser_clk/ser_data=1 in gap.
- LSB-first, falling edge:
  - Stimulus: MSB_FIRST=0, TRANS_EDGE=0, data=8'h85.
  - Required: bits at ser_clk falling edges = 1,0,1,0,0,0,0,1; ser_clk high in first half of each bit.
- Round-robin:
  - Stimulus: req=4'b1111 held continuously.
  - Required: grants in order 0,1,2,3,0; cur_id matches; each grant comes exactly 2 cycles after the preceding done.
- Pointer wrap and withdrawal:
  - Stimulus: after a grant to requester 3, req=4'b0110, then req[1] dropped before the next grant.
  - Required: grant to requester 2 only; pointer becomes 3.
- IDLE_BITS=0, HALF_DIV=1:
  - Stimulus: data=8'hFF.
  - Required: ser_clk toggles every cycle; done on cycle 16 after grant; no gap.
- Reset mid-frame:
  - Stimulus: rst_n low during bit 3.
  - Required: ser_clk=1, ser_data=1, busy=0 asynchronously; after release, the next req starts arbitration from requester 0 and sends a complete fresh frame.
